qmult_sched: RTL and testbench
==============================

# qmult_sched

Round-robin scheduler sharing one sequential sign-magnitude Q-format multiplier among NREQ requesters. Arbitrates requests, launches the multiplier with a one-cycle start pulse, waits a fixed latency, captures product and overflow, and returns them to the granted requester with a valid pulse. Sits between the PPG compute clients and the single multiplier instance.

## Interface
- N, 32, operand/result width (sign-magnitude, bit N-1 is sign)
- Q, 15, fractional bits; pass-through only, no arithmetic here
- NREQ, 4, number of requesters (2..16)
- MUL_LAT, N+4, cycles from start pulse to guaranteed-valid multiplier outputs
- i_clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  NREQ  per-requester request level
- i_a  in  NREQ*N  multiplicand for requester k at [k*N +: N]
- i_b  in  NREQ*N  multiplier for requester k at [k*N +: N]
- o_ack  out  NREQ  one-hot pulse: operands of k captured
- o_valid  out  NREQ  one-hot pulse: o_result/o_overflow belong to k
- o_result  out  N  captured product, held until next capture
- o_overflow  out  1  captured overflow, held with o_result
- o_busy  out  1  high whenever state is not IDLE
- o_err  out  1  sticky: i_mul_complete low at capture
- o_mul_start  out  1  one-cycle start pulse to multiplier
- o_mul_a, o_mul_b  out  N each  registered operands to multiplier
- i_mul_result  in  N  multiplier product
- i_mul_overflow  in  1  multiplier overflow flag
- i_mul_complete  in  1  multiplier done flag (level, sampled only)

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if any i_req, pick winner g = first set bit searching from ptr upward, wrapping; register g, i_a[g], i_b[g] into o_mul_a/o_mul_b; go LAUNCH. No request: stay.
- LAUNCH: o_mul_start=1, o_ack[g]=1; load wait counter with MUL_LAT-1; ptr <= (g+1) mod NREQ; go WAIT.
- WAIT: decrement counter; at 0 capture i_mul_result, i_mul_overflow into o_result/o_overflow; if i_mul_complete=0 set o_err; go DONE.
- DONE: o_valid[g]=1 for one cycle; go IDLE.
- Requester holds i_req and operands until o_ack; drops i_req in ack cycle or later to avoid re-service. Request dropped before grant is simply not served.
- Requests arriving during LAUNCH/WAIT/DONE wait; sampled next IDLE cycle.
- o_mul_a/o_mul_b held constant from IDLE→LAUNCH edge until next grant.
- Round-robin guarantees each persistent requester served within NREQ operations.
- o_err cleared only by rst.

## Timing
- Reset: state IDLE, ptr 0, g 0, counter 0; o_ack, o_valid, o_mul_start, o_busy, o_err, o_overflow = 0; o_result, o_mul_a, o_mul_b = 0.
- Cycle 0: IDLE samples request. Cycle 1: LAUNCH (start, ack). Cycles 2..MUL_LAT+1: WAIT. Cycle MUL_LAT+2: DONE (valid).
- Throughput: one operation per MUL_LAT+3 cycles; no back-to-back skip of IDLE.
- o_busy is 1 in cycles 1..MUL_LAT+2 of each operation.
- rst mid-operation: immediate return to reset values; no o_valid for the aborted op; multiplier reset is not driven by this block.

## Structure
- Package qmult_sched_pkg: state enum (IDLE, LAUNCH, WAIT, DONE), default latency constant, counter width from $clog2(MUL_LAT).
- Sub-module rr_arbiter: combinational one-hot grant from request vector and ptr; pointer register stays in qmult_sched.

## Test plan
- Single request k=0, a=0x00010000, b=0x00018000 (N=32, Q=15, i.e. 2.0×3.0), multiplier model returns 0x00030000 -> o_ack[0] cycle 1, o_valid[0] at cycle MUL_LAT+2, o_result=0x00030000.
- All four requesting continuously -> grant order 0,1,2,3,0; each o_valid matches its own operands.
- ptr=2, requests on 0 and 3 only -> 3 served before 0.
- Model asserts overflow=1, complete=0 at capture -> o_overflow=1 with o_valid, o_err=1 and stays 1.
- rst asserted during WAIT -> all outputs 0 same cycle; no o_valid; next request served normally from ptr 0.
- Request on 1 dropped in IDLE before grant while 2 asserted -> only 2 served, no o_ack[1].

Source files
------------

// File: rtl/qmult_sched_pkg.sv
// Shared types and elaboration helpers for the multiplier scheduler.
package qmult_sched_pkg;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  // Multiplier latency beyond the operand width.
  localparam int unsigned DefLatExtra = 4;

  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qmult_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after i_ptr, wrapping.
module qmult_sched_rr_arbiter import qmult_sched_pkg::*; #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    w_sum   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (PW + 1)'(i);
      if (w_sum >= (PW + 1)'(NREQ)) w_sum = w_sum - (PW + 1)'(NREQ);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qmult_sched.sv
// Shares one sequential Q-format multiplier among NREQ requesters, round-robin.
module qmult_sched import qmult_sched_pkg::*; #(
  parameter int unsigned N       = 32,
  parameter int unsigned Q       = 15,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = N + DefLatExtra
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_a,
  input  logic [NREQ*N-1:0] i_b,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_valid,
  output logic [N-1:0]      o_result,
  output logic              o_overflow,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_mul_start,
  output logic [N-1:0]      o_mul_a,
  output logic [N-1:0]      o_mul_b,
  input  logic [N-1:0]      i_mul_result,
  input  logic              i_mul_overflow,
  input  logic              i_mul_complete
);

  localparam int unsigned PW = idx_width(NREQ);
  localparam int unsigned CW = cnt_width(MUL_LAT);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("qmult_sched: NREQ must be in 2..16");
  end
  if (Q >= N) begin : g_bad_q
    $error("qmult_sched: Q must be below N");
  end

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, r_gnt, w_gnt_idx;
  logic [NREQ-1:0] w_gnt, w_gnt_oh;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_mul_a, r_mul_b, r_result;
  logic            r_overflow, r_err;

  qmult_sched_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (|i_req) w_state_nxt = StLaunch;
      StLaunch: w_state_nxt = StWait;
      StWait:   if (r_cnt == '0) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|i_req) begin
            r_gnt   <= w_gnt_idx;
            r_mul_a <= i_a[N*int'(w_gnt_idx) +: N];
            r_mul_b <= i_b[N*int'(w_gnt_idx) +: N];
          end
        end
        StLaunch: begin
          r_cnt <= CW'(MUL_LAT - 1);
          r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
        end
        StWait: begin
          if (r_cnt == '0) begin
            r_result   <= i_mul_result;
            r_overflow <= i_mul_overflow;
            // Sticky until reset: the multiplier was sampled before it finished.
            if (!i_mul_complete) r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_gnt_oh    = NREQ'(1) << r_gnt;
  assign o_mul_start = (r_state == StLaunch);
  assign o_ack       = (r_state == StLaunch) ? w_gnt_oh : '0;
  assign o_valid     = (r_state == StDone) ? w_gnt_oh : '0;
  assign o_busy      = (r_state != StIdle);
  assign o_result    = r_result;
  assign o_overflow  = r_overflow;
  assign o_err       = r_err;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

endmodule

// File: tb/tb_qmult_sched.sv
// Directed bench for qmult_sched with a transaction-timeline model and a multiplier stub.
module tb_qmult_sched;

  localparam int unsigned N       = 32;
  localparam int unsigned Q       = 15;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = N + 4;
  localparam int          OPLEN   = MUL_LAT + 3;

  logic              i_clk = 1'b0;
  logic              rst   = 1'b1;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ*N-1:0] i_a, i_b;
  logic [NREQ-1:0]   o_ack, o_valid;
  logic [N-1:0]      o_result, o_mul_a, o_mul_b;
  logic              o_overflow, o_busy, o_err, o_mul_start;
  logic [N-1:0]      i_mul_result;
  logic              i_mul_overflow, i_mul_complete;

  logic [N-1:0] opa [NREQ];
  logic [N-1:0] opb [NREQ];
  bit           force_inc = 1'b0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           ackq [$];

  qmult_sched #(
    .N       (N),
    .Q       (Q),
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .i_clk          (i_clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_a            (i_a),
    .i_b            (i_b),
    .o_ack          (o_ack),
    .o_valid        (o_valid),
    .o_result       (o_result),
    .o_overflow     (o_overflow),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_mul_start    (o_mul_start),
    .o_mul_a        (o_mul_a),
    .o_mul_b        (o_mul_b),
    .i_mul_result   (i_mul_result),
    .i_mul_overflow (i_mul_overflow),
    .i_mul_complete (i_mul_complete)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      i_a[k*N +: N] = opa[k];
      i_b[k*N +: N] = opb[k];
    end
  end

  // Sign-magnitude Q product: {overflow, sign, magnitude}.
  function automatic logic [N:0] qmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] p;
    p = ({33'b0, a[N-2:0]} * {33'b0, b[N-2:0]}) >> Q;
    return {|p[63:N-1], a[N-1] ^ b[N-1], p[N-2:0]};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_evt(input bit vld, input int k, output int at);
    at = -1;
    for (int i = 0; i < 3 * OPLEN + 10; i++) begin
      @(negedge i_clk);
      if (vld ? o_valid[k] : o_ack[k]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout waiting for %s[%0d]: got none expected one", vld ? "valid" : "ack", k);
    end
  endtask

  // Multiplier stub: garbage until 20 cycles after start, then the true product.
  initial begin
    int      mcnt;
    logic [N:0] spr;
    mcnt = 0;
    spr  = '0;
    i_mul_result   = '0;
    i_mul_overflow = 1'b0;
    i_mul_complete = 1'b0;
    forever begin
      @(negedge i_clk);
      if (rst) begin
        mcnt = 0;
        i_mul_result   = '0;
        i_mul_overflow = 1'b0;
        i_mul_complete = 1'b0;
      end else if (o_mul_start) begin
        spr  = qmul(o_mul_a, o_mul_b);
        mcnt = 20;
        i_mul_result   = 32'hDEAD_BEEF;
        i_mul_overflow = 1'b0;
        i_mul_complete = 1'b0;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          i_mul_result   = spr[N-1:0];
          i_mul_overflow = spr[N];
          i_mul_complete = !force_inc;
        end
      end
    end
  end

  // Timeline model: each operation spans offsets 0 (IDLE) .. MUL_LAT+2 (DONE).
  initial begin
    int              m_off, m_ptr, m_g;
    logic [N-1:0]    m_res, m_ma, m_mb;
    logic            m_ovf, m_err;
    logic [N:0]      pr;
    logic [NREQ-1:0] oh;
    m_off = 0; m_ptr = 0; m_g = 0;
    m_res = '0; m_ma = '0; m_mb = '0; m_ovf = 1'b0; m_err = 1'b0;
    forever begin
      @(negedge i_clk);
      if (rst) begin
        m_off = 0; m_ptr = 0; m_g = 0;
        m_res = '0; m_ma = '0; m_mb = '0; m_ovf = 1'b0; m_err = 1'b0;
        chk("rst_flags", {o_ack, o_valid, o_busy, o_mul_start, o_err, o_overflow}, '0);
        chk("rst_data", {o_result, o_mul_a}, '0);
        chk("rst_mul_b", o_mul_b, '0);
      end else begin
        oh = '0;
        oh[m_g] = 1'b1;
        if (m_off == 1) begin
          m_ma = opa[m_g];
          m_mb = opb[m_g];
        end
        if (m_off == MUL_LAT + 2) begin
          pr    = qmul(opa[m_g], opb[m_g]);
          m_ovf = pr[N];
          m_res = pr[N-1:0];
          if (force_inc) m_err = 1'b1;
        end
        chk("ack",      o_ack,       (m_off == 1) ? oh : '0);
        chk("start",    o_mul_start, m_off == 1);
        chk("valid",    o_valid,     (m_off == MUL_LAT + 2) ? oh : '0);
        chk("busy",     o_busy,      m_off != 0);
        chk("result",   o_result,    m_res);
        chk("overflow", o_overflow,  m_ovf);
        chk("err",      o_err,       m_err);
        chk("mul_ab",   {o_mul_a, o_mul_b}, {m_ma, m_mb});
        for (int k = 0; k < NREQ; k++) if (o_ack[k]) ackq.push_back(k);
        if (m_off == 0) begin
          if (i_req != '0) begin
            m_g   = pick(i_req, m_ptr);
            m_off = 1;
          end
        end else if (m_off == 1) begin
          m_ptr = (m_g + 1) % NREQ;
          m_off = 2;
        end else if (m_off == MUL_LAT + 2) begin
          m_off = 0;
        end else begin
          m_off++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, c0, ones;
    opa[0] = 32'h0001_0000; opb[0] = 32'h0001_8000;
    opa[1] = 32'h8000_8000; opb[1] = 32'h0001_4000;
    opa[2] = 32'h8000_4000; opb[2] = 32'h8001_0000;
    opa[3] = 32'h0002_0000; opb[3] = 32'h0000_6000;
    repeat (3) @(negedge i_clk);
    chk("reset_busy",  o_busy, 0);
    chk("reset_err",   o_err, 0);
    chk("reset_ack",   o_ack, 0);
    chk("reset_valid", o_valid, 0);
    @(posedge i_clk); #1 rst = 1'b0;
    repeat (2) step();

    // Single request: 2.0 * 3.0
    c0 = cyc;
    i_req[0] = 1'b1;
    wait_evt(0, 0, at);
    chk("t1_ack_cycle", at, c0 + 1);
    step(); i_req[0] = 1'b0;
    wait_evt(1, 0, at);
    chk("t1_valid_cycle", at, c0 + MUL_LAT + 2);
    chk("t1_result", o_result, 32'h0003_0000);
    chk("t1_overflow", o_overflow, 0);

    // Request 1 withdrawn before its grant while 2 waits
    step(); i_req[3] = 1'b1;
    wait_evt(0, 3, at);
    step(); i_req[3] = 1'b0;
    repeat (4) step();
    i_req[2:1] = 2'b11;
    repeat (5) step();
    i_req[1] = 1'b0;
    wait_evt(1, 3, at);
    chk("t3_result", o_result, 32'h0001_8000);
    wait_evt(0, 2, at);
    step(); i_req[2] = 1'b0;
    wait_evt(1, 2, at);
    chk("neg_x_neg_result", o_result, 32'h0000_8000);
    ones = 0;
    foreach (ackq[i]) if (ackq[i] == 1) ones++;
    chk("dropped_req_no_ack1", ones, 0);
    chk("drop_order", {ackq[1][7:0], ackq[2][7:0]}, 16'h0302);

    // Pointer at 2 with requests on 0 and 3
    step(); i_req[1] = 1'b1;
    wait_evt(0, 1, at);
    step(); i_req[1] = 1'b0;
    wait_evt(1, 1, at);
    chk("neg_result", o_result, 32'h8001_4000);
    step(); i_req[0] = 1'b1; i_req[3] = 1'b1;
    wait_evt(0, 3, at);
    step(); i_req[3] = 1'b0;
    wait_evt(0, 0, at);
    step(); i_req[0] = 1'b0;
    wait_evt(1, 0, at);
    chk("ptr2_order", {ackq[4][7:0], ackq[5][7:0]}, 16'h0300);

    // Overflowing product sampled while the multiplier reports not complete
    step();
    force_inc = 1'b1;
    opa[1] = 32'h4000_0000; opb[1] = 32'h4000_0000;
    i_req[1] = 1'b1;
    wait_evt(0, 1, at);
    step(); i_req[1] = 1'b0;
    wait_evt(1, 1, at);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_result", o_result, 32'h0000_0000);
    chk("ovf_err", o_err, 1);
    step();
    force_inc = 1'b0;
    opa[1] = 32'h8000_8000; opb[1] = 32'h0001_4000;
    i_req[2] = 1'b1;
    wait_evt(0, 2, at);
    step(); i_req[2] = 1'b0;
    wait_evt(1, 2, at);
    chk("err_sticky", o_err, 1);
    chk("ovf_cleared", o_overflow, 0);

    // Reset in the middle of WAIT
    step(); i_req[0] = 1'b1;
    wait_evt(0, 0, at);
    step(); i_req[0] = 1'b0;
    repeat (5) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_flags", {o_ack, o_valid, o_busy, o_mul_start, o_err, o_overflow}, '0);
    chk("midrst_result", o_result, '0);
    chk("midrst_mul_ab", {o_mul_a, o_mul_b}, '0);
    @(posedge i_clk); #1 rst = 1'b0;
    ackq.delete();

    // All four requesting continuously from pointer 0
    i_req = '1;
    for (int i = 0; i < 6 * OPLEN && ackq.size() < 5; i++) @(negedge i_clk);
    chk("rr_ack_count", ackq.size() >= 5, 1);
    step(); i_req = '0;
    wait_evt(1, 0, at);
    if (ackq.size() >= 5)
      chk("rr_order", {ackq[0][3:0], ackq[1][3:0], ackq[2][3:0], ackq[3][3:0], ackq[4][3:0]},
          20'h01230);
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
